cv32e40s_data_obi_tracker: RTL

Downstream neighbour of the data write buffer: takes the buffered/bypassed data transfer (valid/ready + `obi_data_req_t`) and drives the OBI data bus. Guarantees OBI address-phase stability, limits outstanding transactions, and matches each response to its request through an in-order tracking FIFO. Responses to bufferable writes carry a flag, and bus errors on them are raised as imprecise errors, since the LSU has already retired those stores.

---
 rtl/cv32e40s_data_obi_tracker_if.sv | 41 ++++
 rtl/cv32e40s_data_obi_tracker.sv | 67 ++++++
 2 files changed

// File: rtl/cv32e40s_data_obi_tracker_if.sv
// cv32e40s_data_obi_tracker_if: transfer type plus the upstream, OBI and response signals of the data OBI tracker
package cv32e40s_data_obi_tracker_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;
endpackage

interface cv32e40s_data_obi_tracker_if;
  import cv32e40s_data_obi_tracker_pkg::*;
  logic          valid_i;
  obi_data_req_t trans_i;
  logic          ready_o;
  logic          obi_req_o;
  obi_data_req_t obi_trans_o;
  logic          obi_gnt_i;
  logic          obi_rvalid_i;
  logic [31:0]   obi_rdata_i;
  logic          obi_err_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic          resp_bufferable_o;
  logic          bus_err_o;
  logic [31:0]   bus_err_addr_o;
  modport master (
    input  valid_i, trans_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    output ready_o, obi_req_o, obi_trans_o, resp_valid_o, resp_rdata_o, resp_err_o,
           resp_bufferable_o, bus_err_o, bus_err_addr_o
  );
  modport slave (
    output valid_i, trans_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  ready_o, obi_req_o, obi_trans_o, resp_valid_o, resp_rdata_o, resp_err_o,
           resp_bufferable_o, bus_err_o, bus_err_addr_o
  );
endinterface

// File: rtl/cv32e40s_data_obi_tracker.sv
// cv32e40s_data_obi_tracker: OBI data address-phase holder, outstanding limiter and in-order response tracker
module cv32e40s_data_obi_tracker
  import cv32e40s_data_obi_tracker_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                           clk,
  input logic                           rst_n,
  cv32e40s_data_obi_tracker_if.master   bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  typedef enum logic {TRANSPARENT, REGISTERED} state_t;
  state_t                     state;
  obi_data_req_t              trans_q;
  logic [CW-1:0]              cnt;
  logic [PW-1:0]              wptr, rptr;
  logic [31:0]                fifo_addr [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_buf;
  logic                       full, issue, pop, pop_buf, bus_err;
  logic [31:0]                bus_err_addr;
  always_comb begin
    full                  = cnt == CW'(MAX_OUTSTANDING);
    bus.obi_req_o         = state == REGISTERED || (bus.valid_i && !full);
    bus.obi_trans_o       = state == REGISTERED ? trans_q : bus.trans_i;
    bus.ready_o           = bus.obi_req_o && bus.obi_gnt_i;
    issue                 = bus.obi_req_o && bus.obi_gnt_i;
    // a response with nothing outstanding is forwarded but never pops the tracker
    pop                   = bus.obi_rvalid_i && cnt != '0;
    pop_buf               = pop && fifo_buf[rptr];
    bus.resp_valid_o      = bus.obi_rvalid_i;
    bus.resp_rdata_o      = bus.obi_rdata_i;
    bus.resp_err_o        = bus.obi_err_i;
    bus.resp_bufferable_o = pop_buf;
    bus.bus_err_o         = bus_err;
    bus.bus_err_addr_o    = bus_err_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= TRANSPARENT;
      trans_q      <= '0;
      cnt          <= '0;
      wptr         <= '0;
      rptr         <= '0;
      fifo_addr    <= '{default: '0};
      fifo_buf     <= '0;
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else begin
      if (state == TRANSPARENT && bus.obi_req_o && !bus.obi_gnt_i) begin
        state   <= REGISTERED;
        trans_q <= bus.trans_i;
      end else if (state == REGISTERED && bus.obi_gnt_i) begin
        state <= TRANSPARENT;
      end
      cnt <= cnt + CW'(issue) - CW'(pop);
      if (issue) begin
        fifo_addr[wptr] <= bus.obi_trans_o.addr;
        fifo_buf[wptr]  <= bus.obi_trans_o.memtype[0] && bus.obi_trans_o.we;
        wptr            <= wptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= rptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rptr + 1'b1;
      bus_err <= pop_buf && bus.obi_err_i;
      if (pop_buf && bus.obi_err_i) bus_err_addr <= fifo_addr[rptr];
    end
  end
endmodule
